// File: rtl/th_scan_sequencer_if.sv
// Handshake/result bundle between the threshold controller side and th_scan_sequencer.
// Optional BLMin/BLMax exist only when TH_SEQ_MINMAX_EN is defined.
interface th_scan_sequencer_if #(
    parameter int unsigned TIMEOUT_W = 16
);
    logic                 Start;
    logic                 Abort;
    logic [TIMEOUT_W-1:0] TimeoutCycles;
    logic                 ScanDone;
    logic [9:0]           BL;
    logic [3:0]           NW;
    logic                 ScanStart;
    logic [9:0]           BLAvg;
    logic [3:0]           NWMax;
    logic                 Busy;
    logic                 Done;
    logic [1:0]           Error;
`ifdef TH_SEQ_MINMAX_EN
    logic [9:0]           BLMin;
    logic [9:0]           BLMax;

    modport master (
        output Start, Abort, TimeoutCycles, ScanDone, BL, NW,
        input  ScanStart, BLAvg, NWMax, Busy, Done, Error, BLMin, BLMax
    );
    modport slave (
        input  Start, Abort, TimeoutCycles, ScanDone, BL, NW,
        output ScanStart, BLAvg, NWMax, Busy, Done, Error, BLMin, BLMax
    );
`else
    modport master (
        output Start, Abort, TimeoutCycles, ScanDone, BL, NW,
        input  ScanStart, BLAvg, NWMax, Busy, Done, Error
    );
    modport slave (
        input  Start, Abort, TimeoutCycles, ScanDone, BL, NW,
        output ScanStart, BLAvg, NWMax, Busy, Done, Error
    );
`endif
endinterface

// File: rtl/th_scan_sequencer.sv
// Baseline calibration sequencer: runs 2**NSCAN_LOG2 scans, averages BL, tracks worst NW.
// Optional BL min/max tracking enabled by defining TH_SEQ_MINMAX_EN.
module th_scan_sequencer #(
    parameter int unsigned NSCAN_LOG2 = 2,
    parameter int unsigned TIMEOUT_W  = 16,
    parameter logic [3:0]  NW_MAX     = 4'd10
) (
    input  logic                CLK,
    input  logic                RSTn,
    th_scan_sequencer_if.slave  bus
);

    // state   | meaning
    // IDLE    | waiting for Start, results held
    // REQ     | ScanStart high, waiting for ScanDone
    // RELEASE | ScanStart low, waiting for ScanDone to fall
    // NEXT    | decide between another scan and FIN
    // FIN     | load results, Done pulse
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_RELEASE = 3'd2,
        S_NEXT    = 3'd3,
        S_FIN     = 3'd4
    } state_t;

    localparam int unsigned ACC_W = 10 + NSCAN_LOG2;
    localparam logic [NSCAN_LOG2-1:0] LAST_SCAN = '1;

    state_t                 state_q, state_d;
    logic [ACC_W-1:0]       acc_q, acc_d;
    logic [NSCAN_LOG2-1:0]  scan_cnt_q, scan_cnt_d;
    logic [TIMEOUT_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [3:0]             nw_acc_q, nw_acc_d;
    logic [1:0]             err_q, err_d;
    logic [9:0]             bl_avg_q, bl_avg_d;
    logic [3:0]             nw_max_q, nw_max_d;
`ifdef TH_SEQ_MINMAX_EN
    logic [9:0]             bl_min_acc_q, bl_min_acc_d;
    logic [9:0]             bl_max_acc_q, bl_max_acc_d;
    logic [9:0]             bl_min_q, bl_min_d;
    logic [9:0]             bl_max_q, bl_max_d;
`endif

    logic                   start_ok;
    logic                   sample;
    logic                   tmo_hit;
    logic                   timeout;
    logic                   finish;
    logic [TIMEOUT_W-1:0]   tmo_last;

    assign tmo_last = bus.TimeoutCycles - TIMEOUT_W'(1);
    assign tmo_hit  = (bus.TimeoutCycles != '0) && (tmo_cnt_q == tmo_last);
    assign start_ok = (state_q == S_IDLE) && bus.Start && !bus.Abort;
    assign sample   = (state_q == S_REQ) && bus.ScanDone && !bus.Abort;
    // A ScanDone edge in the expiry cycle wins: the timeout only fires while still waiting.
    assign timeout  = !bus.Abort && tmo_hit &&
                      (((state_q == S_REQ) && !bus.ScanDone) ||
                       ((state_q == S_RELEASE) && bus.ScanDone));
    assign finish   = (state_q == S_FIN) && !bus.Abort;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if ((state_q != S_IDLE) && bus.Abort) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE:    if (start_ok) state_d = S_REQ;
                S_REQ: begin
                    if (bus.ScanDone)  state_d = S_RELEASE;
                    else if (timeout)  state_d = S_FIN;
                end
                S_RELEASE: begin
                    if (!bus.ScanDone) state_d = S_NEXT;
                    else if (timeout)  state_d = S_FIN;
                end
                S_NEXT:    state_d = (scan_cnt_q == LAST_SCAN) ? S_FIN : S_REQ;
                S_FIN:     state_d = S_IDLE;
                default:   state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.ScanStart = (state_q == S_REQ);
        bus.Busy      = (state_q != S_IDLE);
        bus.Done      = finish;
        bus.BLAvg     = bl_avg_q;
        bus.NWMax     = nw_max_q;
        bus.Error     = err_q;
`ifdef TH_SEQ_MINMAX_EN
        bus.BLMin     = bl_min_q;
        bus.BLMax     = bl_max_q;
`endif
    end

    always_comb begin
        acc_d      = acc_q;
        scan_cnt_d = scan_cnt_q;
        nw_acc_d   = nw_acc_q;
        err_d      = err_q;
        bl_avg_d   = bl_avg_q;
        nw_max_d   = nw_max_q;
`ifdef TH_SEQ_MINMAX_EN
        bl_min_acc_d = bl_min_acc_q;
        bl_max_acc_d = bl_max_acc_q;
        bl_min_d     = bl_min_q;
        bl_max_d     = bl_max_q;
`endif

        if (start_ok) begin
            acc_d      = '0;
            scan_cnt_d = '0;
            nw_acc_d   = '0;
            err_d      = '0;
`ifdef TH_SEQ_MINMAX_EN
            bl_min_acc_d = 10'd1023;
            bl_max_acc_d = 10'd0;
`endif
        end

        if (sample) begin
            acc_d = acc_q + {{NSCAN_LOG2{1'b0}}, bus.BL};
            if (bus.NW > nw_acc_q) nw_acc_d = bus.NW;
            if (bus.NW > NW_MAX)   err_d[1] = 1'b1;
`ifdef TH_SEQ_MINMAX_EN
            if (bus.BL < bl_min_acc_q) bl_min_acc_d = bus.BL;
            if (bus.BL > bl_max_acc_q) bl_max_acc_d = bus.BL;
`endif
        end

        if (timeout) err_d[0] = 1'b1;

        if ((state_q == S_NEXT) && !bus.Abort && (scan_cnt_q != LAST_SCAN)) begin
            scan_cnt_d = scan_cnt_q + NSCAN_LOG2'(1);
        end

        // Counter restarts on every state change, so REQ and RELEASE each get a full budget.
        if ((state_d == state_q) && ((state_q == S_REQ) || (state_q == S_RELEASE))) begin
            tmo_cnt_d = tmo_cnt_q + TIMEOUT_W'(1);
        end else begin
            tmo_cnt_d = '0;
        end

        if (finish) begin
            bl_avg_d = acc_q[ACC_W-1:NSCAN_LOG2];
            nw_max_d = nw_acc_q;
`ifdef TH_SEQ_MINMAX_EN
            bl_min_d = bl_min_acc_q;
            bl_max_d = bl_max_acc_q;
`endif
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            acc_q      <= '0;
            scan_cnt_q <= '0;
            tmo_cnt_q  <= '0;
            nw_acc_q   <= '0;
            err_q      <= '0;
            bl_avg_q   <= '0;
            nw_max_q   <= '0;
`ifdef TH_SEQ_MINMAX_EN
            bl_min_acc_q <= 10'd1023;
            bl_max_acc_q <= 10'd0;
            bl_min_q     <= 10'd1023;
            bl_max_q     <= 10'd0;
`endif
        end else begin
            acc_q      <= acc_d;
            scan_cnt_q <= scan_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            nw_acc_q   <= nw_acc_d;
            err_q      <= err_d;
            bl_avg_q   <= bl_avg_d;
            nw_max_q   <= nw_max_d;
`ifdef TH_SEQ_MINMAX_EN
            bl_min_acc_q <= bl_min_acc_d;
            bl_max_acc_q <= bl_max_acc_d;
            bl_min_q     <= bl_min_d;
            bl_max_q     <= bl_max_d;
`endif
        end
    end

endmodule

// File: tb/tb_th_scan_sequencer.sv
// Directed bench for th_scan_sequencer (NSCAN_LOG2=2); min/max checks follow TH_SEQ_MINMAX_EN.
module tb_th_scan_sequencer;
    localparam int TW = 16;

    logic CLK  = 1'b0;
    logic RSTn = 1'b1;
    int   vectors = 0;
    int   errors  = 0;
    int   done_seen = 0;
    int   ss_rises  = 0;
    logic ss_prev   = 1'b0;

    th_scan_sequencer_if #(.TIMEOUT_W(TW)) bus ();

    th_scan_sequencer #(.NSCAN_LOG2(2), .TIMEOUT_W(TW), .NW_MAX(4'd10)) dut (
        .CLK  (CLK),
        .RSTn (RSTn),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (bus.Done === 1'b1) done_seen++;
        if (bus.ScanStart === 1'b1 && ss_prev !== 1'b1) ss_rises++;
        ss_prev = bus.ScanStart;
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic start_pulse;
        bus.Start = 1'b1;
        tick;
        bus.Start = 1'b0;
    endtask

    task automatic wait_ss(input logic lvl, inout bit ok);
        int n = 0;
        while (bus.ScanStart !== lvl && n < 200) begin
            tick;
            n++;
        end
        if (bus.ScanStart !== lvl) ok = 1'b0;
    endtask

    // Ideal upstream: answers each ScanStart after dly cycles, releases ScanDone as soon as ScanStart falls.
    task automatic respond(input logic [9:0] bl [4], input logic [3:0] nw [4], input int dly [4],
                           input int abort_scan, output bit ok);
        int n;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_ss(1'b1, ok);
            if (!ok) return;
            if (i == abort_scan) begin
                bus.Abort = 1'b1;
                tick;
                bus.Abort = 1'b0;
                return;
            end
            repeat (dly[i]) tick;
            bus.ScanDone = 1'b1;
            bus.BL = bl[i];
            bus.NW = nw[i];
            wait_ss(1'b0, ok);
            if (!ok) return;
            bus.ScanDone = 1'b0;
        end
        n = 0;
        while (bus.Done !== 1'b1 && n < 100) begin
            tick;
            n++;
        end
        if (bus.Done !== 1'b1) ok = 1'b0;
        else tick;
    endtask

    task automatic test_reset;
        bus.Start = 0; bus.Abort = 0; bus.TimeoutCycles = '0; bus.ScanDone = 0; bus.BL = '0; bus.NW = '0;
        #3 RSTn = 1'b0;
        tick; tick;
        vectors++; if (bus.ScanStart !== 1'b0) begin errors++; $display("FAIL reset_scanstart: got %b expected 0", bus.ScanStart); end
        vectors++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.Busy); end
        vectors++; if (bus.Done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.Done); end
        vectors++; if (bus.Error !== 2'b00) begin errors++; $display("FAIL reset_error: got %b expected 00", bus.Error); end
        vectors++; if (bus.BLAvg !== 10'd0) begin errors++; $display("FAIL reset_blavg: got %0d expected 0", bus.BLAvg); end
        vectors++; if (bus.NWMax !== 4'd0) begin errors++; $display("FAIL reset_nwmax: got %0d expected 0", bus.NWMax); end
`ifdef TH_SEQ_MINMAX_EN
        vectors++; if (bus.BLMin !== 10'd1023) begin errors++; $display("FAIL reset_blmin: got %0d expected 1023", bus.BLMin); end
        vectors++; if (bus.BLMax !== 10'd0) begin errors++; $display("FAIL reset_blmax: got %0d expected 0", bus.BLMax); end
`endif
        #2 RSTn = 1'b1;
        tick;
    endtask

    task automatic test_idle_ignore;
        bus.ScanDone = 1'b1; bus.BL = 10'd999;
        tick; tick; tick;
        vectors++; if (bus.Busy !== 1'b0 || bus.ScanStart !== 1'b0) begin errors++; $display("FAIL idle_scandone: got busy=%b ss=%b expected 0 0", bus.Busy, bus.ScanStart); end
        bus.ScanDone = 1'b0;
        bus.Start = 1'b1; bus.Abort = 1'b1;
        tick;
        bus.Start = 1'b0; bus.Abort = 1'b0;
        vectors++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL start_with_abort: got busy=%b expected 0", bus.Busy); end
    endtask

    task automatic test_basic;
        logic [9:0] bl [4]; logic [3:0] nw [4]; int dly [4]; bit ok; int d0, s0;
        bl = '{10'd100, 10'd102, 10'd104, 10'd106}; nw = '{4'd3, 4'd5, 4'd2, 4'd4}; dly = '{1, 0, 2, 1};
        d0 = done_seen; s0 = ss_rises;
        start_pulse;
        vectors++; if (bus.ScanStart !== 1'b1 || bus.Busy !== 1'b1) begin errors++; $display("FAIL basic_latency: got ss=%b busy=%b expected 1 1", bus.ScanStart, bus.Busy); end
        bus.Start = 1'b1;  // Start while Busy must be ignored
        tick;
        bus.Start = 1'b0;
        respond(bl, nw, dly, -1, ok);
        vectors++; if (!ok) begin errors++; $display("FAIL basic_handshake: got stalled expected completion"); end
        vectors++; if (bus.BLAvg !== 10'd103) begin errors++; $display("FAIL basic_blavg: got %0d expected 103", bus.BLAvg); end
        vectors++; if (bus.NWMax !== 4'd5) begin errors++; $display("FAIL basic_nwmax: got %0d expected 5", bus.NWMax); end
        vectors++; if (bus.Error !== 2'b00) begin errors++; $display("FAIL basic_error: got %b expected 00", bus.Error); end
        vectors++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b expected 0", bus.Busy); end
        vectors++; if (done_seen - d0 !== 1) begin errors++; $display("FAIL basic_done_count: got %0d expected 1", done_seen - d0); end
        vectors++; if (ss_rises - s0 !== 4) begin errors++; $display("FAIL basic_scanstart_count: got %0d expected 4", ss_rises - s0); end
    endtask

    task automatic test_truncate;
        logic [9:0] bl [4]; logic [3:0] nw [4]; int dly [4]; bit ok;
        bl = '{10'd101, 10'd102, 10'd102, 10'd102}; nw = '{4'd1, 4'd1, 4'd1, 4'd1}; dly = '{0, 0, 0, 0};
        start_pulse;
        respond(bl, nw, dly, -1, ok);
        vectors++; if (!ok) begin errors++; $display("FAIL trunc_handshake: got stalled expected completion"); end
        vectors++; if (bus.BLAvg !== 10'd101) begin errors++; $display("FAIL trunc_blavg: got %0d expected 101", bus.BLAvg); end
        vectors++; if (bus.NWMax !== 4'd1) begin errors++; $display("FAIL trunc_nwmax: got %0d expected 1", bus.NWMax); end
`ifdef TH_SEQ_MINMAX_EN
        vectors++; if (bus.BLMin !== 10'd101) begin errors++; $display("FAIL trunc_blmin: got %0d expected 101", bus.BLMin); end
        vectors++; if (bus.BLMax !== 10'd102) begin errors++; $display("FAIL trunc_blmax: got %0d expected 102", bus.BLMax); end
`endif
    endtask

    task automatic test_noise;
        logic [9:0] bl [4]; logic [3:0] nw [4]; int dly [4]; bit ok; int d0, s0;
        bl = '{10'd200, 10'd200, 10'd200, 10'd200}; nw = '{4'd3, 4'd12, 4'd3, 4'd3}; dly = '{1, 1, 1, 1};
        d0 = done_seen; s0 = ss_rises;
        start_pulse;
        respond(bl, nw, dly, -1, ok);
        vectors++; if (!ok) begin errors++; $display("FAIL noise_handshake: got stalled expected completion"); end
        vectors++; if (bus.Error !== 2'b10) begin errors++; $display("FAIL noise_error: got %b expected 10", bus.Error); end
        vectors++; if (bus.NWMax !== 4'd12) begin errors++; $display("FAIL noise_nwmax: got %0d expected 12", bus.NWMax); end
        vectors++; if (bus.BLAvg !== 10'd200) begin errors++; $display("FAIL noise_blavg: got %0d expected 200", bus.BLAvg); end
        vectors++; if (ss_rises - s0 !== 4 || done_seen - d0 !== 1) begin errors++; $display("FAIL noise_counts: got ss=%0d done=%0d expected 4 1", ss_rises - s0, done_seen - d0); end
    endtask

    task automatic test_timeout;
        int d0;
        bus.TimeoutCycles = TW'(50);
        d0 = done_seen;
        start_pulse;
        repeat (49) tick;
        vectors++; if (bus.ScanStart !== 1'b1 || bus.Done !== 1'b0) begin errors++; $display("FAIL tmo_early: got ss=%b done=%b expected 1 0", bus.ScanStart, bus.Done); end
        tick;
        vectors++; if (bus.ScanStart !== 1'b0) begin errors++; $display("FAIL tmo_scanstart: got %b expected 0", bus.ScanStart); end
        vectors++; if (bus.Done !== 1'b1) begin errors++; $display("FAIL tmo_done: got %b expected 1", bus.Done); end
        vectors++; if (bus.Error !== 2'b01) begin errors++; $display("FAIL tmo_error: got %b expected 01", bus.Error); end
        tick;
        vectors++; if (bus.BLAvg !== 10'd0 || bus.NWMax !== 4'd0) begin errors++; $display("FAIL tmo_partial: got blavg=%0d nwmax=%0d expected 0 0", bus.BLAvg, bus.NWMax); end
        vectors++; if (bus.Busy !== 1'b0 || done_seen - d0 !== 1) begin errors++; $display("FAIL tmo_end: got busy=%b done=%0d expected 0 1", bus.Busy, done_seen - d0); end
        bus.TimeoutCycles = '0;
    endtask

    task automatic test_timeout_tie;
        logic [9:0] bl [4]; logic [3:0] nw [4]; int dly [4]; bit ok;
        bl = '{10'd400, 10'd404, 10'd408, 10'd412}; nw = '{4'd0, 4'd0, 4'd0, 4'd0}; dly = '{2, 0, 0, 0};
        bus.TimeoutCycles = TW'(3);
        start_pulse;
        respond(bl, nw, dly, -1, ok);
        vectors++; if (!ok) begin errors++; $display("FAIL tie_handshake: got stalled expected completion"); end
        vectors++; if (bus.Error !== 2'b00) begin errors++; $display("FAIL tie_error: got %b expected 00", bus.Error); end
        vectors++; if (bus.BLAvg !== 10'd406) begin errors++; $display("FAIL tie_blavg: got %0d expected 406", bus.BLAvg); end
        bus.TimeoutCycles = '0;
    endtask

    task automatic test_abort;
        logic [9:0] bl [4]; logic [3:0] nw [4]; int dly [4]; bit ok; int d0, s0;
        bl = '{10'd10, 10'd20, 10'd30, 10'd40}; nw = '{4'd15, 4'd1, 4'd1, 4'd1}; dly = '{0, 1, 0, 0};
        nw[0] = 4'd2;
        d0 = done_seen; s0 = ss_rises;
        start_pulse;
        respond(bl, nw, dly, 2, ok);
        vectors++; if (!ok) begin errors++; $display("FAIL abort_handshake: got stalled expected abort point"); end
        vectors++; if (bus.ScanStart !== 1'b0 || bus.Busy !== 1'b0) begin errors++; $display("FAIL abort_idle: got ss=%b busy=%b expected 0 0", bus.ScanStart, bus.Busy); end
        vectors++; if (bus.BLAvg !== 10'd406 || bus.Error !== 2'b00) begin errors++; $display("FAIL abort_retain: got blavg=%0d err=%b expected 406 00", bus.BLAvg, bus.Error); end
        vectors++; if (done_seen - d0 !== 0 || ss_rises - s0 !== 3) begin errors++; $display("FAIL abort_counts: got done=%0d ss=%0d expected 0 3", done_seen - d0, ss_rises - s0); end
        bl = '{10'd500, 10'd501, 10'd502, 10'd503}; nw = '{4'd1, 4'd2, 4'd3, 4'd4}; dly = '{0, 0, 0, 0};
        d0 = done_seen; s0 = ss_rises;
        start_pulse;
        respond(bl, nw, dly, -1, ok);
        vectors++; if (!ok) begin errors++; $display("FAIL rerun_handshake: got stalled expected completion"); end
        vectors++; if (bus.BLAvg !== 10'd501 || bus.NWMax !== 4'd4) begin errors++; $display("FAIL rerun_result: got blavg=%0d nwmax=%0d expected 501 4", bus.BLAvg, bus.NWMax); end
        vectors++; if (done_seen - d0 !== 1 || ss_rises - s0 !== 4) begin errors++; $display("FAIL rerun_counts: got done=%0d ss=%0d expected 1 4", done_seen - d0, ss_rises - s0); end
`ifdef TH_SEQ_MINMAX_EN
        vectors++; if (bus.BLMin !== 10'd500 || bus.BLMax !== 10'd503) begin errors++; $display("FAIL rerun_minmax: got %0d/%0d expected 500/503", bus.BLMin, bus.BLMax); end
`endif
    endtask

    task automatic test_full_scale;
        logic [9:0] bl [4]; logic [3:0] nw [4]; int dly [4]; bit ok;
        bl = '{10'd1023, 10'd1023, 10'd1023, 10'd1023}; nw = '{4'd0, 4'd0, 4'd0, 4'd0}; dly = '{0, 3, 0, 1};
        start_pulse;
        respond(bl, nw, dly, -1, ok);
        vectors++; if (!ok) begin errors++; $display("FAIL full_handshake: got stalled expected completion"); end
        vectors++; if (bus.BLAvg !== 10'd1023) begin errors++; $display("FAIL full_blavg: got %0d expected 1023", bus.BLAvg); end
        vectors++; if (bus.Error !== 2'b00) begin errors++; $display("FAIL full_error: got %b expected 00", bus.Error); end
    endtask

    task automatic test_reset_mid;
        start_pulse;
        bus.ScanDone = 1'b1; bus.BL = 10'd7; bus.NW = 4'd9;
        tick;
        vectors++; if (bus.ScanStart !== 1'b0 || bus.Busy !== 1'b1) begin errors++; $display("FAIL mid_release: got ss=%b busy=%b expected 0 1", bus.ScanStart, bus.Busy); end
        #2 RSTn = 1'b0;
        #1;
        vectors++; if (bus.ScanStart !== 1'b0 || bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin errors++; $display("FAIL mid_rst_ctrl: got ss=%b busy=%b done=%b expected 0 0 0", bus.ScanStart, bus.Busy, bus.Done); end
        vectors++; if (bus.BLAvg !== 10'd0 || bus.NWMax !== 4'd0 || bus.Error !== 2'b00) begin errors++; $display("FAIL mid_rst_data: got blavg=%0d nwmax=%0d err=%b expected 0 0 00", bus.BLAvg, bus.NWMax, bus.Error); end
`ifdef TH_SEQ_MINMAX_EN
        vectors++; if (bus.BLMin !== 10'd1023 || bus.BLMax !== 10'd0) begin errors++; $display("FAIL mid_rst_minmax: got %0d/%0d expected 1023/0", bus.BLMin, bus.BLMax); end
`endif
        bus.ScanDone = 1'b0;
        tick;
        #2 RSTn = 1'b1;
        tick;
    endtask

    initial begin
        test_reset;
        test_idle_ignore;
        test_basic;
        test_truncate;
        test_noise;
        test_timeout;
        test_timeout_tie;
        test_abort;
        test_full_scale;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1);
    end
endmodule
